// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2**N decoder with an auto-scan mode.
// Mode=0 decodes W directly; Mode=1 steps the index every DIV enabled,
// unheld cycles, with Load/Hold overrides and a one-cycle Wrap pulse.
module dec_scan #(
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              En,
  input  logic              Mode,
  input  logic              Load,
  input  logic              Hold,
  input  logic [N-1:0]      W,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      Idx,
  output logic              Wrap
);

  // A 1-bit prescaler is kept for DIV=1; it simply stays at 0.
  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [2**N-1:0] y_q,    y_d;
  logic [N-1:0]    idx_q,  idx_d;
  logic [PW-1:0]   pre_q,  pre_d;
  logic            wrap_q, wrap_d;

  function automatic logic [2**N-1:0] onehot(input logic [N-1:0] v);
    logic [2**N-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Next-state: Reset (in the flop) > En=0 > direct > Load > Hold > step.
  // Whenever enabled, Y is rebuilt from the resulting index so it can never
  // drift from Idx, including on the first edge after En returns to 1.
  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    if (!En) begin
      y_d = '0;
    end else if (!Mode || Load) begin
      idx_d = W;
      pre_d = '0;
      y_d   = onehot(W);
    end else if (Hold) begin
      y_d = onehot(idx_q);
    end else if (pre_q == LAST) begin
      pre_d  = '0;
      idx_d  = idx_q + 1'b1;
      y_d    = onehot(idx_q + 1'b1);
      wrap_d = (idx_q == '1);
    end else begin
      pre_d = pre_q + 1'b1;
      y_d   = onehot(idx_q);
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      y_q    <= '0;
      idx_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign Idx  = idx_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: two instances (N=4/DIV=4 and N=3/DIV=1).
// Stimulus pushes hand-computed expectations; per-instance monitors pop and
// compare one entry after each rising edge.
module tb_dec_scan;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
    string       nm;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  logic       a_en = 0, a_mode = 0, a_load = 0, a_hold = 0;
  logic [3:0] a_w = '0;
  logic [15:0] a_y;
  logic [3:0]  a_idx;
  logic        a_wrap;

  logic       b_en = 0, b_mode = 0, b_load = 0, b_hold = 0;
  logic [2:0] b_w = '0;
  logic [7:0] b_y;
  logic [2:0] b_idx;
  logic       b_wrap;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  dec_scan #(.N(4), .DIV(4)) u_a (
    .Clock(Clock), .Reset(Reset), .En(a_en), .Mode(a_mode), .Load(a_load),
    .Hold(a_hold), .W(a_w), .Y(a_y), .Idx(a_idx), .Wrap(a_wrap));

  dec_scan #(.N(3), .DIV(1)) u_b (
    .Clock(Clock), .Reset(Reset), .En(b_en), .Mode(b_mode), .Load(b_load),
    .Hold(b_hold), .W(b_w), .Y(b_y), .Idx(b_idx), .Wrap(b_wrap));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitors: one expectation per rising edge while entries are pending.
  always @(posedge Clock) begin
    #1;
    if (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      chk({e.nm, ".A.Y"},    32'(a_y),    32'(e.y));
      chk({e.nm, ".A.Idx"},  32'(a_idx),  32'(e.idx));
      chk({e.nm, ".A.Wrap"}, 32'(a_wrap), 32'(e.wrap));
    end
  end

  always @(posedge Clock) begin
    #1;
    if (qb.size() > 0) begin
      exp_t e;
      e = qb.pop_front();
      chk({e.nm, ".B.Y"},    32'(b_y),    32'(e.y));
      chk({e.nm, ".B.Idx"},  32'(b_idx),  32'(e.idx));
      chk({e.nm, ".B.Wrap"}, 32'(b_wrap), 32'(e.wrap));
    end
  end

  task automatic step_a(input logic en, mode, load, hold, input logic [3:0] w,
                        input logic [15:0] ey, input logic [3:0] ei, input logic ew,
                        input string nm);
    exp_t e;
    @(negedge Clock);
    a_en = en; a_mode = mode; a_load = load; a_hold = hold; a_w = w;
    e.y = ey; e.idx = ei; e.wrap = ew; e.nm = nm;
    qa.push_back(e);
    @(posedge Clock);
  endtask

  task automatic step_b(input logic en, mode, load, hold, input logic [2:0] w,
                        input logic [7:0] ey, input logic [2:0] ei, input logic ew,
                        input string nm);
    exp_t e;
    @(negedge Clock);
    b_en = en; b_mode = mode; b_load = load; b_hold = hold; b_w = w;
    e.y = 16'(ey); e.idx = 4'(ei); e.wrap = ew; e.nm = nm;
    qb.push_back(e);
    @(posedge Clock);
  endtask

  initial begin
    logic [3:0] ei;
    exp_t e;

    // Reset state
    #2;
    chk("rst.A.Y", 32'(a_y), 0);   chk("rst.A.Idx", 32'(a_idx), 0);
    chk("rst.A.Wrap", 32'(a_wrap), 0);
    chk("rst.B.Y", 32'(b_y), 0);   chk("rst.B.Idx", 32'(b_idx), 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Direct decode, then disable freezes Idx and blanks Y
    step_a(1, 0, 0, 0, 4'h9, 16'h0200, 4'h9, 0, "direct9");
    step_a(0, 0, 0, 0, 4'h5, 16'h0000, 4'h9, 0, "disable");
    step_a(0, 1, 1, 0, 4'h3, 16'h0000, 4'h9, 0, "disable_load");

    // Load 0xE, scan: F after 4 edges, 0 with Wrap after 8, on to Idx=5/pre=2
    step_a(1, 1, 1, 0, 4'hE, 16'h4000, 4'hE, 0, "loadE");
    for (int c = 1; c <= 30; c++) begin
      ei = (c < 4) ? 4'hE : (c < 8) ? 4'hF : 4'(c / 4 - 2);
      step_a(1, 1, 0, 0, 4'h0, 16'h1 << ei, ei, (c == 8), $sformatf("scan%0d", c));
    end

    // Hold for 10 cycles at Idx=5, then Load+Hold wins with W=3
    for (int c = 0; c < 10; c++)
      step_a(1, 1, 0, 1, 4'hC, 16'h0020, 4'h5, 0, "hold");
    step_a(1, 1, 1, 1, 4'h3, 16'h0008, 4'h3, 0, "load_over_hold");
    for (int c = 1; c <= 4; c++)
      step_a(1, 1, 0, 0, 4'h0, (c < 4) ? 16'h0008 : 16'h0010,
             (c < 4) ? 4'h3 : 4'h4, 0, "after_load");

    // Mode switch: scanning at A, direct W=2, back to scan -> 3 after DIV edges
    step_a(1, 1, 1, 0, 4'hA, 16'h0400, 4'hA, 0, "loadA");
    step_a(1, 1, 0, 0, 4'h0, 16'h0400, 4'hA, 0, "scanA1");
    step_a(1, 1, 0, 0, 4'h0, 16'h0400, 4'hA, 0, "scanA2");
    step_a(1, 0, 0, 0, 4'h2, 16'h0004, 4'h2, 0, "mode0_w2");
    for (int c = 1; c <= 4; c++)
      step_a(1, 1, 0, 0, 4'h0, (c < 4) ? 16'h0004 : 16'h0008,
             (c < 4) ? 4'h2 : 4'h3, 0, "mode1_resume");

    // Enable gap mid-count: prescaler (at 2) and Idx freeze, Y blanks
    step_a(1, 1, 0, 0, 4'h0, 16'h0008, 4'h3, 0, "pre1");
    step_a(1, 1, 0, 0, 4'h0, 16'h0008, 4'h3, 0, "pre2");
    for (int c = 0; c < 3; c++)
      step_a(0, 1, 0, 0, 4'h0, 16'h0000, 4'h3, 0, "en_gap");
    step_a(1, 1, 0, 0, 4'h0, 16'h0008, 4'h3, 0, "reen_pre3");
    step_a(1, 1, 0, 0, 4'h0, 16'h0010, 4'h4, 0, "reen_step");

    // Load to 0 from F raises no Wrap
    step_a(1, 1, 1, 0, 4'hF, 16'h8000, 4'hF, 0, "loadF");
    step_a(1, 1, 1, 0, 4'h0, 16'h0001, 4'h0, 0, "load0_nowrap");

    // Async reset mid-scan at Idx=7
    step_a(1, 1, 1, 0, 4'h7, 16'h0080, 4'h7, 0, "load7");
    step_a(1, 1, 0, 0, 4'h0, 16'h0080, 4'h7, 0, "scan7");
    @(negedge Clock);
    a_en = 1; a_mode = 1; a_load = 0; a_hold = 0;
    Reset = 1'b1;
    #1;
    chk("async.Y", 32'(a_y), 0);
    chk("async.Idx", 32'(a_idx), 0);
    chk("async.Wrap", 32'(a_wrap), 0);
    #1;
    Reset = 1'b0;
    e.y = 16'h0001; e.idx = 4'h0; e.wrap = 0; e.nm = "post_rst1";
    qa.push_back(e);
    @(posedge Clock);
    step_a(1, 1, 0, 0, 4'h0, 16'h0001, 4'h0, 0, "post_rst2");
    step_a(1, 1, 0, 0, 4'h0, 16'h0001, 4'h0, 0, "post_rst3");
    step_a(1, 1, 0, 0, 4'h0, 16'h0002, 4'h1, 0, "post_rst_step");
    step_a(0, 0, 0, 0, 4'h0, 16'h0000, 4'h1, 0, "a_park");

    // DIV=1 sweep on N=3: two full laps, Wrap on each return to 0
    step_b(1, 0, 0, 0, 3'h0, 8'h01, 3'h0, 0, "b_direct0");
    for (int c = 1; c <= 16; c++)
      step_b(1, 1, 0, 0, 3'h0, 8'h01 << (c % 8), 3'(c % 8), ((c % 8) == 0),
             $sformatf("sweep%0d", c));
    step_b(1, 1, 0, 1, 3'h5, 8'h01, 3'h0, 0, "b_hold");
    step_b(1, 1, 0, 0, 3'h0, 8'h02, 3'h1, 0, "b_after_hold");

    repeat (3) @(posedge Clock);
    #2;
    chk("queues_drained", 32'(qa.size() + qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
